// File: rtl/datamem_responder.sv
// Word-organised data memory behind a request/response handshake.
// Big-endian byte/halfword lanes, fixed wait latency, error responses.
module datamem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        accept;
    logic        commit;

    logic        wr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          err;
    logic [AW-1:0] idx;
    logic [31:0]   cur_word;
    logic [31:0]   byte_sh;
    logic [31:0]   half_sh;
    logic [31:0]   load_val;
    logic [31:0]   lane_mask;
    logic [31:0]   lane_data;
    logic [31:0]   store_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Alignment/size legality, plus any address bit above the array
    always_comb begin
        unique case (size_q)
            2'b00:   err = (addr_q[1:0] != 2'b00);
            2'b01:   err = addr_q[0];
            2'b10:   err = 1'b0;
            default: err = 1'b1;
        endcase
        if (addr_q[31:AW+2] != '0) begin
            err = 1'b1;
        end
    end

    assign idx      = addr_q[AW+1:2];
    assign cur_word = mem[idx];
    // Offset 0 is the most significant lane, so shift by the inverted offset
    assign byte_sh  = cur_word >> {~addr_q[1:0], 3'b000};
    assign half_sh  = cur_word >> {~addr_q[1], 4'b0000};

    always_comb begin
        load_val  = cur_word;
        lane_mask = 32'hFFFF_FFFF;
        lane_data = wdata_q;
        unique case (size_q)
            2'b01: begin
                load_val  = {{16{half_sh[15] & ~uns_q}}, half_sh[15:0]};
                lane_mask = 32'h0000_FFFF << {~addr_q[1], 4'b0000};
                lane_data = {16'h0000, wdata_q[15:0]} << {~addr_q[1], 4'b0000};
            end
            2'b10: begin
                load_val  = {{24{byte_sh[7] & ~uns_q}}, byte_sh[7:0]};
                lane_mask = 32'h0000_00FF << {~addr_q[1:0], 3'b000};
                lane_data = {24'h00_0000, wdata_q[7:0]} << {~addr_q[1:0], 3'b000};
            end
            default: ;
        endcase
        store_word = (cur_word & ~lane_mask) | (lane_data & lane_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= 4'd0;
            wr_q       <= 1'b0;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            if (accept) begin
                wr_q    <= req_write;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= 4'(LATENCY);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                resp_err   <= err;
                resp_rdata <= (err || wr_q) ? 32'h0 : load_val;
                if (!err && wr_q) begin
                    mem[idx] <= store_word;
                end
            end
        end
    end

endmodule

// File: doc/datamem_responder.md
DATAMEM_RESPONDER -- requirements
Module: datamem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words in storage; power of two, 4 to 1024.
REQ-002 Parameter LATENCY, default 2, wait cycles spent in BUSY per request; range 0 to 15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 word, 01 halfword, 10 byte, 11 illegal.
REQ-009 req_unsigned  input  1  loads: 1 zero-extends, 0 sign-extends sub-word data.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, right-justified for sub-word stores.
REQ-012 resp_valid  output  1  response available.
REQ-013 resp_ready  input  1  initiator accepts the response.
REQ-014 resp_rdata  output  32  load result, extended per req_unsigned; 0 for stores and errors.
REQ-015 resp_err  output  1  request was misaligned, out of range or illegal size.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and RESP.
REQ-017 req_ready SHALL be 1 only in IDLE; resp_valid SHALL be 1 only in RESP.
REQ-018 The handshake SHALL complete on an edge where req_valid=1 and req_ready=1; on that edge, write, size, unsigned, addr and wdata SHALL be latched, the wait counter loaded with LATENCY, and the FSM SHALL go to BUSY.
REQ-019 In BUSY, the FSM SHALL decrement the counter each edge while it is nonzero; on the edge where the counter is 0, it SHALL go to RESP.
REQ-020 Response latency: resp_valid SHALL rise after edge E0+LATENCY+1, where E0 is the accept edge.
REQ-021 Commit point: the store write or load capture SHALL occur on the BUSY->RESP edge, and at no other time.
REQ-022 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until an edge with resp_ready=1; the FSM SHALL then return to IDLE.
REQ-023 Back-to-back requests SHALL incur a minimum of one IDLE cycle between responses.
REQ-024 Byte order SHALL be big-endian.
REQ-025 Byte lanes: byte offset 0 -> bits [31:24]; offset 3 -> bits [7:0].
REQ-026 Halfword lanes: offset 0 -> bits [31:16]; offset 2 -> bits [15:0].
REQ-027 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2].
REQ-028 Sub-word stores SHALL modify only the addressed lanes; all other bytes SHALL be preserved.
REQ-029 Error conditions SHALL be: halfword with addr[0]=1; word with addr[1:0]!=00; req_size=11; addr >= 4*DEPTH_WORDS.
REQ-030 On error, no storage SHALL be modified, resp_err SHALL be 1 and resp_rdata SHALL be 0; latency SHALL be unchanged.
REQ-031 Inputs other than resp_ready SHALL be ignored outside the accept edge; changes to req_* during BUSY or RESP SHALL have no effect.
REQ-032 Address wrap-around SHALL NOT occur; out-of-range addresses SHALL always error.

Reset
REQ-033 Reset assertion SHALL immediately force IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 (once reset is released), and clear all storage words to 0.
REQ-034 A reset asserted in BUSY before the commit edge SHALL discard the request and perform no write.
REQ-035 After reset deassertion, the first request SHALL be acceptable on the first rising edge.

Verification
REQ-036 Word store then load, LATENCY=2: store 0xDEADBEEF at 0x10, then load 0x10 -> resp_valid 3 edges after each accept; load returns 0xDEADBEEF with resp_err=0.
REQ-037 Byte lanes: store byte 0x80 at 0x13, then load byte signed at 0x13 -> 0xFFFFFF80; load unsigned -> 0x00000080; load word 0x10 -> 0xDEADBE80.
REQ-038 Errors: load word at 0x12, load half at 0x11, store at 0x100 (DEPTH 64) -> resp_err=1 and rdata=0 for each; follow-up load of 0x10 is unchanged.
REQ-039 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready=0 throughout; the edge with resp_ready=1 returns the FSM to IDLE.
REQ-040 Reset mid-op: assert reset one cycle after accepting a store of 0x12345678 to 0x20 -> outputs cleared immediately; subsequent load of 0x20 returns 0x00000000.
REQ-041 LATENCY=0: accept at E0 -> resp_valid high after E0+1; back-to-back stream of 4 loads completes with one IDLE cycle between each.
